// File: rtl/aqp_reset_req_gen.sv
// aqp_reset_req_gen: merges button, software-key and optional watchdog requests into a one-cycle reset_req strobe.
// Define AQP_WDT_EN to include the watchdog; without it wdt_enable/wdt_kick are ignored and reset_cause[2] stays 0.
module aqp_reset_req_gen #(
    parameter int DEBOUNCE_BITS = 18,
    parameter int WDT_BITS      = 24
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       button_n,
    input  logic       ebus_reset_n,
    input  logic       sw_wr,
    input  logic [7:0] sw_data,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    input  logic       cause_clr,
    output logic       reset_req,
    output logic [2:0] reset_cause
);
    typedef enum logic {KEY_IDLE, KEY_ARMED} key_state_t;

    // Synchronisers, debounced state and cause survive reset, so they only carry power-up values.
    logic btn_s1_q = 1'b1;
    logic btn_s2_q = 1'b1;
    logic ebus_s1_q = 1'b1;
    logic ebus_s2_q = 1'b1;
    logic btn_db_q = 1'b1;
    logic btn_prev_q = 1'b1;
    logic [2:0] cause_q = 3'b000;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q;
    key_state_t key_q;
    logic req_q;
    logic ev_btn, ev_sw, ev_wdt, accept;
    logic [2:0] ev_vec, cause_d;

    always_ff @(posedge sysclk) begin
        btn_s1_q   <= button_n;
        btn_s2_q   <= btn_s1_q;
        ebus_s1_q  <= ebus_reset_n;
        ebus_s2_q  <= ebus_s1_q;
        btn_prev_q <= btn_db_q;
        if (reset || btn_s2_q == btn_db_q) db_cnt_q <= '0;
        else if (&db_cnt_q) begin
            db_cnt_q <= '0;
            btn_db_q <= btn_s2_q;
        end else db_cnt_q <= db_cnt_q + DEBOUNCE_BITS'(1);
    end

    assign ev_btn = btn_prev_q & ~btn_db_q;

    // Any write other than the arm byte drops back to idle; the arm byte always (re)arms.
    always_ff @(posedge sysclk) begin
        if (reset) key_q <= KEY_IDLE;
        else if (sw_wr) key_q <= (sw_data == 8'hA5) ? KEY_ARMED : KEY_IDLE;
    end

    assign ev_sw = sw_wr && key_q == KEY_ARMED && sw_data == 8'h5A;

`ifdef AQP_WDT_EN
    logic [WDT_BITS-1:0] wdt_q;

    always_ff @(posedge sysclk) begin
        if (reset || !wdt_enable || wdt_kick) wdt_q <= '0;
        else wdt_q <= wdt_q + WDT_BITS'(1);
    end

    assign ev_wdt = wdt_enable & ~wdt_kick & (&wdt_q);
`else
    logic [WDT_BITS-1:0] unused_wdt;

    assign unused_wdt = {WDT_BITS{wdt_enable ^ wdt_kick}};
    assign ev_wdt     = 1'b0;
`endif

    assign ev_vec  = {ev_wdt, ev_sw, ev_btn};
    assign accept  = (|ev_vec) & ebus_s2_q & ~reset;
    assign cause_d = (cause_clr ? 3'b000 : cause_q) | (accept ? ev_vec : 3'b000);

    always_ff @(posedge sysclk) begin
        cause_q <= cause_d;
        req_q   <= accept;
    end

    assign reset_req   = req_q;
    assign reset_cause = cause_q;
endmodule

// File: tb/tb_aqp_reset_req_gen.sv
// tb_aqp_reset_req_gen: directed vectors with a scoreboard of expected reset_req pulses (cycle and cause).
module tb_aqp_reset_req_gen;
    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       button_n = 1'b1;
    logic       ebus_reset_n = 1'b1;
    logic       sw_wr = 1'b0;
    logic [7:0] sw_data = 8'h00;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       cause_clr = 1'b0;
    logic       reset_req;
    logic [2:0] reset_cause;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int c0 = 0;

    typedef struct packed {
        logic [2:0] cause;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    aqp_reset_req_gen #(.DEBOUNCE_BITS(4), .WDT_BITS(6)) dut (
        .sysclk(sysclk),
        .reset(reset),
        .button_n(button_n),
        .ebus_reset_n(ebus_reset_n),
        .sw_wr(sw_wr),
        .sw_data(sw_data),
        .wdt_enable(wdt_enable),
        .wdt_kick(wdt_kick),
        .cause_clr(cause_clr),
        .reset_req(reset_req),
        .reset_cause(reset_cause)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sw(input logic [7:0] d, input bit pulse, input logic [2:0] c);
        sw_wr = 1'b1;
        sw_data = d;
        if (pulse) sb.push_back('{c, cyc + 1});
        tick();
        sw_wr = 1'b0;
    endtask

    always @(negedge sysclk) begin
        if (reset_req) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: reset_req=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("pulse_cause", int'(reset_cause), int'(e.cause));
            end
        end
    end

    initial begin
        tick(3);
        check("reset_req_in_reset", int'(reset_req), 0);
        check("cause_powerup", int'(reset_cause), 0);
        reset = 1'b0;
        tick(2);
        sw(8'hA5, 0, 3'b000);
        sw(8'h5A, 1, 3'b010);
        tick(5);
        sw(8'hA5, 0, 3'b000);
        sw(8'h00, 0, 3'b000);
        sw(8'h5A, 0, 3'b000);
        tick(3);
        sw(8'hA5, 0, 3'b000);
        sw(8'hA5, 0, 3'b000);
        sw(8'h5A, 1, 3'b010);
        tick(5);
        sw(8'hA5, 0, 3'b000);
        reset = 1'b1;
        tick(10);
        check("cause_held_in_reset", int'(reset_cause), 2);
        check("req_low_in_reset", int'(reset_req), 0);
        reset = 1'b0;
        tick(2);
        sw(8'h5A, 0, 3'b000);
        tick(3);
        ebus_reset_n = 1'b0;
        tick(4);
        sw(8'hA5, 0, 3'b000);
        sw(8'h5A, 0, 3'b000);
        tick(3);
        check("cause_gated", int'(reset_cause), 2);
        ebus_reset_n = 1'b1;
        tick(4);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        tick();
        check("cause_clr", int'(reset_cause), 0);
        button_n = 1'b0;
        tick(10);
        button_n = 1'b1;
        tick(6);
        check("cause_after_bounce", int'(reset_cause), 0);
        button_n = 1'b0;
        sb.push_back('{3'b001, cyc + 19});
        tick(240);
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(40);
        check("cause_button", int'(reset_cause), 1);
        button_n = 1'b1;
        tick(30);
        sw(8'hA5, 0, 3'b000);
        sw(8'h5A, 1, 3'b011);
        tick(3);
        button_n = 1'b0;
        c0 = cyc;
        tick(18);
        cause_clr = 1'b1;
        sb.push_back('{3'b001, c0 + 19});
        tick();
        cause_clr = 1'b0;
        tick(30);
        check("clr_vs_event", int'(reset_cause), 1);
        button_n = 1'b1;
        tick(30);
`ifdef AQP_WDT_EN
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        wdt_enable = 1'b1;
        repeat (10) begin
            tick(49);
            wdt_kick = 1'b1;
            c0 = cyc;
            tick();
            wdt_kick = 1'b0;
        end
        sb.push_back('{3'b100, c0 + 65});
        tick(80);
        wdt_enable = 1'b0;
        check("cause_wdt", int'(reset_cause), 4);
`else
        wdt_enable = 1'b1;
        tick(100);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        tick(100);
        wdt_enable = 1'b0;
        check("cause_no_wdt", int'(reset_cause), 1);
`endif
        tick(5);
        check("pulses_outstanding", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
